// File: rtl/adder_arbiter_if.sv
// Bundle between the requester clients and the shared-adder arbiter:
// per-requester request/operand lanes, the one-hot grant, and the tagged result handshake.
interface adder_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ)
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] a_flat;
  logic [NREQ*WIDTH-1:0] b_flat;
  logic [NREQ-1:0]       gnt;
  logic                  sum_valid;
  logic                  sum_ready;
  logic [WIDTH-1:0]      sum;
  logic                  carry;
  logic [IDW-1:0]        sum_id;

  // Client side: drives requests and operands, consumes the result.
  modport master (
    output req, a_flat, b_flat, sum_ready,
    input  gnt, sum_valid, sum, carry, sum_id
  );

  // Arbiter side.
  modport slave (
    input  req, a_flat, b_flat, sum_ready,
    output gnt, sum_valid, sum, carry, sum_id
  );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit adder among NREQ requesters.
// One operation every 3 cycles minimum; the result is held until the consumer accepts it.
module adder_arbiter #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  adder_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [IDW-1:0]   r_last;
  logic [IDW-1:0]   r_idx;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [NREQ-1:0]  r_gnt;
  logic             r_sum_valid;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [IDW-1:0]   r_sum_id;

  logic             w_found;
  logic [IDW-1:0]   w_winner;
  logic             w_capture;
  logic             w_execute;
  logic             w_release;

  // Search starts one past the previous winner so every requester gets a turn.
  always_comb begin : p_rr_search
    logic [IDW-1:0] idx;
    // NOTE: every comb output gets a default first, so no path leaves it unassigned (no latch).
    w_found  = 1'b0;
    w_winner = '0;
    idx      = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = IDW'((int'(r_last) + i) % NREQ);
      if (!w_found && bus.req[idx]) begin
        w_found  = 1'b1;
        w_winner = idx;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      // NOTE: non-blocking assignments in clocked blocks keep all registers updating from pre-edge values.
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_found)       w_state_nxt = S_EXEC;
      S_EXEC:                     w_state_nxt = S_OUT;
      S_OUT:   if (bus.sum_ready) w_state_nxt = S_IDLE;
      default:                    w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode: strobes that steer the registered datapath
  always_comb begin
    w_capture = 1'b0;
    w_execute = 1'b0;
    w_release = 1'b0;
    case (r_state)
      S_IDLE:  w_capture = w_found;
      S_EXEC:  w_execute = 1'b1;
      S_OUT:   w_release = bus.sum_ready;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: operand latches and result registers are reset too, so an aborted operation leaves nothing behind.
      r_last      <= IDW'(NREQ - 1);
      r_idx       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_gnt       <= '0;
      r_sum_valid <= 1'b0;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_sum_id    <= '0;
    end else begin
      r_gnt <= '0;
      if (w_capture) begin
        r_gnt  <= NREQ'(1) << w_winner;
        r_last <= w_winner;
        r_idx  <= w_winner;
        r_a    <= bus.a_flat[int'(w_winner)*WIDTH +: WIDTH];
        r_b    <= bus.b_flat[int'(w_winner)*WIDTH +: WIDTH];
      end
      if (w_execute) begin
        {r_carry, r_sum} <= {1'b0, r_a} + {1'b0, r_b};
        r_sum_id         <= r_idx;
        r_sum_valid      <= 1'b1;
      end
      if (w_release) begin
        r_sum_valid <= 1'b0;
      end
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.sum_valid = r_sum_valid;
  assign bus.sum       = r_sum;
  assign bus.carry     = r_carry;
  assign bus.sum_id    = r_sum_id;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: reset, single ops, carry, round-robin order,
// backpressure, fairness and asynchronous reset in the middle of an operation.
module tb_adder_arbiter;
  localparam int WIDTH = 32;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  adder_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

  adder_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bus.a_flat[i*WIDTH +: WIDTH] = a;
    bus.b_flat[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic scramble_lanes();
    for (int i = 0; i < NREQ; i++) set_lane(i, $urandom, $urandom);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // Single-requester operation with sum_ready high; returns what was observed.
  task automatic run_op(input int idx, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        output logic [NREQ-1:0] g, output logic v, output logic [WIDTH-1:0] s,
                        output logic c, output logic [IDW-1:0] id, output logic v_after);
    scramble_lanes();
    set_lane(idx, a, b);
    bus.sum_ready = 1'b1;
    bus.req       = NREQ'(1) << idx;
    tick();
    g       = bus.gnt;
    bus.req = '0;
    tick();
    v  = bus.sum_valid;
    s  = bus.sum;
    c  = bus.carry;
    id = bus.sum_id;
    tick();
    v_after = bus.sum_valid;
  endtask

  task automatic test_reset();
    logic [NREQ+WIDTH+IDW+1:0] outs;
    bus.req       = '0;
    bus.sum_ready = 1'b0;
    scramble_lanes();
    rst_n = 1'b0;
    tick();
    outs = {bus.gnt, bus.sum_valid, bus.sum, bus.carry, bus.sum_id};
    checks++;
    if (outs !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", outs);
    end
    rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.gnt !== 4'b0000 || bus.sum_valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_req got gnt=%b valid=%b exp gnt=0000 valid=0", bus.gnt, bus.sum_valid);
    end
  endtask

  task automatic test_single();
    logic [NREQ-1:0]  g;
    logic             v, c, va;
    logic [WIDTH-1:0] s;
    logic [IDW-1:0]   id;
    logic [WIDTH-1:0] ta [2] = '{32'd3, 32'd22332};
    logic [WIDTH-1:0] tb [2] = '{32'd4, 32'd13342};
    logic [WIDTH-1:0] ts [2] = '{32'd7, 32'd35674};
    for (int k = 0; k < 2; k++) begin
      run_op(0, ta[k], tb[k], g, v, s, c, id, va);
      checks++;
      if (g !== 4'b0001) begin
        failures++;
        $display("FAIL single_gnt[%0d] got=%b exp=0001", k, g);
      end
      checks++;
      if ({v, c, s, id} !== {1'b1, 1'b0, ts[k], 2'd0}) begin
        failures++;
        $display("FAIL single_result[%0d] got v=%b c=%b s=%0d id=%0d exp v=1 c=0 s=%0d id=0",
                 k, v, c, s, id, ts[k]);
      end
      checks++;
      if (va !== 1'b0) begin
        failures++;
        $display("FAIL single_release[%0d] got valid=%b exp=0", k, va);
      end
    end
  endtask

  task automatic test_carry();
    logic [NREQ-1:0]  g;
    logic             v, c, va;
    logic [WIDTH-1:0] s;
    logic [IDW-1:0]   id;
    int               ti [2] = '{3, 1};
    logic [WIDTH-1:0] ta [2] = '{32'hFFFF_FFFF, 32'h8000_0000};
    logic [WIDTH-1:0] tb [2] = '{32'h0000_0001, 32'h8000_0000};
    for (int k = 0; k < 2; k++) begin
      run_op(ti[k], ta[k], tb[k], g, v, s, c, id, va);
      checks++;
      if ({g, v, c, s, id} !== {NREQ'(1) << ti[k], 1'b1, 1'b1, 32'd0, IDW'(ti[k])}) begin
        failures++;
        $display("FAIL carry[%0d] got g=%b v=%b c=%b s=%h id=%0d exp g=%b v=1 c=1 s=0 id=%0d",
                 k, g, v, c, s, id, NREQ'(1) << ti[k], ti[k]);
      end
    end
  endtask

  task automatic test_all_req();
    logic [NREQ-1:0] eg;
    int              e;
    do_reset();
    for (int i = 0; i < NREQ; i++) set_lane(i, WIDTH'(10 * i), WIDTH'(i));
    bus.sum_ready = 1'b1;
    bus.req       = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      e  = k % NREQ;
      eg = NREQ'(1) << e;
      tick();
      checks++;
      if (bus.gnt !== eg) begin
        failures++;
        $display("FAIL all_gnt[%0d] got=%b exp=%b", k, bus.gnt, eg);
      end
      tick();
      checks++;
      if ({bus.sum_valid, bus.carry, bus.sum, bus.sum_id} !== {1'b1, 1'b0, WIDTH'(11 * e), IDW'(e)}) begin
        failures++;
        $display("FAIL all_result[%0d] got v=%b s=%0d id=%0d exp v=1 s=%0d id=%0d",
                 k, bus.sum_valid, bus.sum, bus.sum_id, 11 * e, e);
      end
      tick();
    end
    bus.req = '0;
    tick();
  endtask

  task automatic test_backpressure();
    bus.sum_ready = 1'b1;
    set_lane(0, 32'd5, 32'd6);
    set_lane(1, 32'd100, 32'd1);
    bus.req = 4'b0001;
    tick();
    checks++;
    if (bus.gnt !== 4'b0001) begin
      failures++;
      $display("FAIL bp_first_gnt got=%b exp=0001", bus.gnt);
    end
    bus.req       = 4'b0010;
    bus.sum_ready = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if ({bus.sum_valid, bus.sum, bus.sum_id, bus.gnt} !== {1'b1, 32'd11, 2'd0, 4'b0000}) begin
        failures++;
        $display("FAIL bp_hold[%0d] got v=%b s=%0d id=%0d gnt=%b exp v=1 s=11 id=0 gnt=0000",
                 k, bus.sum_valid, bus.sum, bus.sum_id, bus.gnt);
      end
    end
    bus.sum_ready = 1'b1;
    tick();
    checks++;
    if (bus.sum_valid !== 1'b0 || bus.gnt !== 4'b0000) begin
      failures++;
      $display("FAIL bp_release got v=%b gnt=%b exp v=0 gnt=0000", bus.sum_valid, bus.gnt);
    end
    tick();
    checks++;
    if (bus.gnt !== 4'b0010) begin
      failures++;
      $display("FAIL bp_pending_gnt got=%b exp=0010", bus.gnt);
    end
    bus.req = '0;
    tick();
    checks++;
    if ({bus.sum_valid, bus.sum, bus.sum_id} !== {1'b1, 32'd101, 2'd1}) begin
      failures++;
      $display("FAIL bp_pending_result got v=%b s=%0d id=%0d exp v=1 s=101 id=1",
               bus.sum_valid, bus.sum, bus.sum_id);
    end
    tick();
  endtask

  task automatic test_fairness();
    int exp_id [7] = '{0, 2, 0, 2, 0, 1, 2};
    do_reset();
    set_lane(0, 32'd1, 32'd1);
    set_lane(1, 32'd100, 32'd100);
    set_lane(2, 32'd20, 32'd2);
    bus.sum_ready = 1'b1;
    bus.req       = 4'b0101;
    for (int k = 0; k < 7; k++) begin
      if (k == 4) bus.req = 4'b0111;
      tick();
      checks++;
      if (bus.gnt !== NREQ'(1) << exp_id[k]) begin
        failures++;
        $display("FAIL fair_gnt[%0d] got=%b exp=%b", k, bus.gnt, NREQ'(1) << exp_id[k]);
      end
      tick();
      checks++;
      if (bus.sum_id !== IDW'(exp_id[k])) begin
        failures++;
        $display("FAIL fair_id[%0d] got=%0d exp=%0d", k, bus.sum_id, exp_id[k]);
      end
      tick();
    end
    bus.req = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    logic [NREQ+WIDTH+IDW+1:0] outs;
    set_lane(0, 32'd7, 32'd8);
    set_lane(2, 32'd20, 32'd2);
    bus.sum_ready = 1'b1;
    bus.req       = 4'b0001;
    tick();
    checks++;
    if (bus.gnt !== 4'b0001) begin
      failures++;
      $display("FAIL mid_gnt got=%b exp=0001", bus.gnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    outs = {bus.gnt, bus.sum_valid, bus.sum, bus.carry, bus.sum_id};
    checks++;
    if (outs !== '0) begin
      failures++;
      $display("FAIL mid_async_clear got=%h exp=0", outs);
    end
    bus.req = 4'b0100;
    tick();
    checks++;
    if (bus.sum_valid !== 1'b0 || bus.gnt !== 4'b0000) begin
      failures++;
      $display("FAIL mid_held got v=%b gnt=%b exp v=0 gnt=0000", bus.sum_valid, bus.gnt);
    end
    #2;
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.gnt !== 4'b0100) begin
      failures++;
      $display("FAIL mid_after_gnt got=%b exp=0100", bus.gnt);
    end
    bus.req = '0;
    tick();
    checks++;
    if ({bus.sum_valid, bus.sum, bus.sum_id} !== {1'b1, 32'd22, 2'd2}) begin
      failures++;
      $display("FAIL mid_after_result got v=%b s=%0d id=%0d exp v=1 s=22 id=2",
               bus.sum_valid, bus.sum, bus.sum_id);
    end
    tick();
    bus.req = 4'b1111;
    do_reset();
    tick();
    checks++;
    if (bus.gnt !== 4'b0001) begin
      failures++;
      $display("FAIL mid_all_gnt got=%b exp=0001", bus.gnt);
    end
    bus.req = '0;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_carry();
    test_all_req();
    test_backpressure();
    test_fairness();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin arbiter and sequencer that shares one WIDTH-bit adder among NREQ requesters. It accepts one operand pair at a time from the winning requester and returns a registered sum and carry-out, tagged with the requester index. A valid/ready handshake on the result side provides backpressure. It sits between the client blocks and the shared n-bit adder datapath.

## Interface
- WIDTH, 32, operand/sum width
- NREQ, 4, number of requesters (≥2)
- IDW, $clog2(NREQ), requester index width (derived)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req  in  NREQ  per-requester request level
- a_flat  in  NREQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH]
- b_flat  in  NREQ*WIDTH  operand B; same packing
- gnt  out  NREQ  one-hot, one-cycle pulse: operands of that requester were captured
- sum_valid  out  1  result available
- sum_ready  in  1  result consumer ready
- sum  out  WIDTH  (A+B) mod 2^WIDTH
- carry  out  1  bit WIDTH of A+B
- sum_id  out  IDW  index of the requester that owns sum

## Operation
- FSM states: IDLE, EXEC, OUT.
- IDLE: if req != 0 at the edge:
  - pick the winner round-robin, searching from (last+1) mod NREQ upward with wrap.
  - latch its A and B and its index.
  - gnt[winner] <= 1; last <= winner; go to EXEC.
  - If req == 0, stay in IDLE and keep gnt at 0.
- EXEC (1 cycle):
  - {carry,sum} <= A_lat + B_lat, computed at WIDTH+1 bits.
  - sum_id <= latched index; sum_valid <= 1; gnt <= 0; go to OUT.
  - req is not sampled in this state.
- OUT:
  - sum, carry, sum_id and sum_valid hold stable while sum_ready = 0.
  - On an edge with sum_ready = 1: sum_valid <= 0, go to IDLE.
  - req is not sampled in this state.
- Requester protocol:
  - Hold req and the operands stable until gnt is seen.
  - Drop req in the gnt cycle unless another operation is wanted.
  - req still high when the FSM returns to IDLE counts as a new request.
- Fairness: any continuously requesting client is granted within NREQ operations.
- The operand lanes of non-winners are ignored.
- Reset (async, any state, including mid-EXEC/OUT):
  - State goes to IDLE and last = NREQ-1, so requester 0 wins first.
  - gnt = 0, sum_valid = 0, sum = 0, carry = 0, sum_id = 0.
  - Operand latches are cleared.
  - An in-flight operation is discarded and produces no sum_valid.

## Timing
- Edge k (IDLE, req sampled): gnt high during cycle k..k+1.
- Edge k+1: sum_valid rises, with sum, carry and sum_id valid.
- Edge k+2 with sum_ready = 1: sum_valid falls and the state returns to IDLE.
- Edge k+3: earliest next capture.
- Minimum issue interval: 3 cycles per operation. Each cycle of sum_ready low adds 1.
- Request-to-result latency: 2 edges. Result outputs are registered; there is no combinational path from inputs to outputs.
- sum_ready high while sum_valid is low has no effect.

## Test plan
- Single requester: NREQ=4, req=0001, a0=3, b0=4, sum_ready=1 → gnt=0001 for one cycle; next cycle sum_valid=1, sum=7, carry=0, sum_id=0. A second case, a0=22332 and b0=13342, gives sum=35674.
- All request at once: after reset, req=1111 held high with ai=10·i and bi=i → grants in order 0,1,2,3,0. Sums are 0, 11, 22, 33, tagged with the matching sum_id.
- Carry/wrap: a=32'hFFFFFFFF, b=1 → sum=0, carry=1. A second case, a=32'h80000000 twice, gives sum=0, carry=1.
- Backpressure: sum_ready=0 for 5 cycles after sum_valid rises, with req=0010 pending → sum, sum_id and sum_valid stay constant and no gnt is issued. Raising sum_ready frees the FSM, and the pending request is granted 2 edges later.
- Fairness: req[0] and req[2] held high continuously → gnt alternates 0,2,0,2. req[1] raised mid-run is granted within 2 operations.
- Reset mid-operation: assert rst_n=0 asynchronously during EXEC → gnt, sum_valid, sum, carry and sum_id go to 0 immediately, with no result emitted. After release with req=0100, requester 2 wins first if it is the only one requesting. With req=1111, requester 0 wins.
